// File: rtl/pipeline_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_pkg : shared types and constants for the memory-access stage
// Revision     : 1.0
// ---------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] c_base_addr = 32'd1024;
  localparam int          c_cnt_w     = 4;

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_memory : word-wide storage, synchronous write, registered read port
// Revision    : 1.0
// ---------------------------------------------------------------------------
module data_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  // Every word is cleared on reset, so the array is built from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        r_mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= r_mem[raddr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_stage : pipeline MEM stage with fixed-latency data memory
// Revision         : 1.0
// ---------------------------------------------------------------------------
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 3,
  parameter logic [31:0] BASE_ADDR = c_base_addr
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] src2_val,
  input  logic [4:0]  dest,
  output logic        stall,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic [31:0] result_out,
  output logic [4:0]  dest_out
);

  localparam int                 AW       = $clog2(DEPTH);
  localparam logic [c_cnt_w-1:0] c_lat_m1 = c_cnt_w'(LATENCY - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [AW-1:0]      w_idx;
  logic               w_is_mem;
  logic               w_is_load;
  logic               w_last;
  logic [31:0]        w_rdata;

  assign w_idx     = AW'((alu_result - BASE_ADDR) >> 2);
  assign w_is_mem  = mem_read | mem_write;
  assign w_is_load = mem_read & ~mem_write;

  // The IDLE cycle that first sees the op is itself a stall cycle, so BUSY
  // lasts LATENCY-1 cycles and the counter holds the BUSY cycles still to go.
  assign w_last = ((r_state == IDLE) && w_is_mem && (c_lat_m1 == '0)) ||
                  ((r_state == BUSY) && (r_cnt == c_cnt_w'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_mem) begin
            r_cnt   <= c_lat_m1;
            r_state <= (c_lat_m1 == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  data_memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_last & mem_write),
    .waddr (w_idx),
    .wdata (src2_val),
    .re    (w_last & w_is_load),
    .raddr (w_idx),
    .rdata (w_rdata)
  );

  // Stall is forced low while reset is held so the upstream never freezes.
  assign stall = rst_n & (((r_state == IDLE) & w_is_mem) | (r_state == BUSY));

  assign wb_en_out    = wb_en & ~stall;
  assign mem_read_out = mem_read & ~stall;
  assign dest_out     = dest;

  always_comb begin
    result_out = alu_result;
    if (mem_write) begin
      result_out = '0;
    end else if (mem_read) begin
      result_out = w_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access_stage : directed vectors and multi-cycle sequences
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] src2_val;
  logic [4:0]  dest;
  logic        stall;
  logic        wb_en_out;
  logic        mem_read_out;
  logic [31:0] result_out;
  logic [4:0]  dest_out;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(
    .DEPTH     (DEPTH),
    .LATENCY   (LAT),
    .BASE_ADDR (32'd1024)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_en        (wb_en),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .alu_result   (alu_result),
    .src2_val     (src2_val),
    .dest         (dest),
    .stall        (stall),
    .wb_en_out    (wb_en_out),
    .mem_read_out (mem_read_out),
    .result_out   (result_out),
    .dest_out     (dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        exp_wb;
    logic [31:0] exp_res;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_nop();
    wb_en      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_result = '0;
    src2_val   = '0;
    dest       = '0;
  endtask

  // Presents one load/store, checks LAT stall cycles with bubbles, then the
  // DONE cycle outputs, then one idle cycle with no stall.
  task automatic mem_op(input string nm, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] d, input logic [31:0] exp_res);
    wb_en      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    alu_result = addr;
    src2_val   = data;
    dest       = d;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk({nm, " stall"}, stall, 1'b1);
      chk({nm, " bubble wb"}, wb_en_out, 1'b0);
      chk({nm, " bubble mr"}, mem_read_out, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({nm, " done stall"}, stall, 1'b0);
    chk({nm, " done result"}, result_out, exp_res);
    chk({nm, " done mr"}, mem_read_out, rd);
    chk({nm, " done wb"}, wb_en_out, 1'b1);
    chk({nm, " done dest"}, dest_out, d);
    @(posedge clk); #1;
    set_nop();
    @(negedge clk);
    chk({nm, " idle stall"}, stall, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0055, 5'd7,  1'b1, 32'h0000_0055, 5'd7};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'hFFFF_FFFF, 5'd31};
    vecs[2] = '{1'b1, 32'h0000_0404, 5'd0,  1'b1, 32'h0000_0404, 5'd0};
    vecs[3] = '{1'b1, 32'h8000_0001, 5'd18, 1'b1, 32'h8000_0001, 5'd18};

    // Outputs during reset follow the IDLE rules, and stall stays low.
    rst_n = 1'b0;
    set_nop();
    wb_en      = 1'b1;
    alu_result = 32'h55;
    dest       = 5'd7;
    #2;
    chk("rst result", result_out, 32'h55);
    chk("rst dest", dest_out, 5'd7);
    chk("rst wb", wb_en_out, 1'b1);
    chk("rst stall", stall, 1'b0);
    mem_write = 1'b1;
    #1;
    chk("rst memop stall", stall, 1'b0);
    chk("rst memop wb", wb_en_out, 1'b1);
    set_nop();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wb_en      = vecs[i].wb_en;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_result = vecs[i].alu;
      dest       = vecs[i].dest;
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), stall, 1'b0);
      chk($sformatf("vec%0d wb", i), wb_en_out, vecs[i].exp_wb);
      chk($sformatf("vec%0d mr", i), mem_read_out, 1'b0);
      chk($sformatf("vec%0d result", i), result_out, vecs[i].exp_res);
      chk($sformatf("vec%0d dest", i), dest_out, vecs[i].exp_dest);
      @(posedge clk); #1;
    end
    set_nop();

    mem_op("st1028", 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 5'd3, 32'h0);
    mem_op("ld1028", 1'b1, 1'b0, 32'd1028, 32'h0, 5'd4, 32'hDEAD_BEEF);
    mem_op("ld1031", 1'b1, 1'b0, 32'd1031, 32'h0, 5'd5, 32'hDEAD_BEEF);
    mem_op("stwrap", 1'b0, 1'b1, 32'd1024 + 32'(4 * DEPTH) + 32'd8, 32'hCAFE_F00D, 5'd6, 32'h0);
    mem_op("ld1032", 1'b1, 1'b0, 32'd1032, 32'h0, 5'd8, 32'hCAFE_F00D);
    mem_op("both1040", 1'b1, 1'b1, 32'd1040, 32'h0000_1234, 5'd9, 32'h0);
    mem_op("ld1040", 1'b1, 1'b0, 32'd1040, 32'h0, 5'd10, 32'h0000_1234);

    // Reset lands in the second BUSY cycle of a store; the store is lost.
    wb_en      = 1'b1;
    mem_write  = 1'b1;
    alu_result = 32'd1044;
    src2_val   = 32'h0BAD_F00D;
    dest       = 5'd11;
    @(negedge clk);
    chk("abort stall0", stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort stall1", stall, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort rst stall", stall, 1'b0);
    chk("abort rst wb", wb_en_out, 1'b1);
    set_nop();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort idle stall", stall, 1'b0);
    @(posedge clk); #1;

    mem_op("ld1044", 1'b1, 1'b0, 32'd1044, 32'h0, 5'd12, 32'h0);
    mem_op("ld1028rst", 1'b1, 1'b0, 32'd1028, 32'h0, 5'd13, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
